// File: rtl/mem_arbiter_if.sv
// Bundle between the core's fetch/data ports, the arbiter and the single-port RAM.
// slave = arbiter side; master = core + RAM side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic [DATA_W-1:0] if_rdata;
  logic              if_rvalid;

  logic              d_ren;
  logic [3:0]        d_wen;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic [DATA_W-1:0] d_rdata;
  logic              d_rvalid;

  logic              ram_en;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  if_req, if_addr, d_ren, d_wen, d_addr, d_wdata, ram_rdata,
    output if_gnt, if_rdata, if_rvalid, d_gnt, d_rdata, d_rvalid,
           ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output if_req, if_addr, d_ren, d_wen, d_addr, d_wdata, ram_rdata,
    input  if_gnt, if_rdata, if_rvalid, d_gnt, d_rdata, d_rvalid,
           ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access, one grant per cycle.
// Optional fetch starvation guard compiled in with `define ARB_STARVE_GUARD_EN.
//
// read tag | meaning
// ---------+---------------------------------------------
// TAG_NONE | no read outstanding, both rvalid low
// TAG_IF   | fetch read issued last cycle, if_rvalid now
// TAG_D    | load read issued last cycle, d_rvalid now
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic            clk,
  input  logic            rst,
  mem_arbiter_if.slave    bus,
  output logic            hold_o
);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_IF   = 2'd1,
    TAG_D    = 2'd2
  } tag_e;

  tag_e tag_q, tag_d;
  logic d_store, d_pend;
  logic if_win, d_win;
  logic force_if;

  always_comb begin
    d_store = |bus.d_wen;
    d_pend  = d_store | bus.d_ren;
    if_win  = 1'b0;
    d_win   = 1'b0;
    if (!rst) begin
      if (force_if)        if_win = 1'b1;
      else if (d_pend)     d_win  = 1'b1;
      else if (bus.if_req) if_win = 1'b1;
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_q, starve_d;

  assign force_if = bus.if_req && (starve_q == CNT_W'(STARVE_LIMIT));

  always_comb begin
    starve_d = starve_q;
    if (!bus.if_req || if_win)
      starve_d = '0;
    else if (starve_q != CNT_W'(STARVE_LIMIT))
      starve_d = starve_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end
`else
  assign force_if = 1'b0;
`endif

  assign bus.if_gnt    = if_win;
  assign bus.d_gnt     = d_win;
  assign bus.ram_en    = if_win | d_win;
  assign bus.ram_we    = d_win ? bus.d_wen : 4'b0000;
  assign bus.ram_addr  = d_win ? bus.d_addr : bus.if_addr;
  assign bus.ram_wdata = d_win ? bus.d_wdata : '0;

  assign hold_o = ~rst & ((bus.if_req & ~if_win) | (d_pend & ~d_win));

  // A combined load+store request is a store: it gets no read tag.
  always_comb begin
    tag_d = TAG_NONE;
    if (d_win && !d_store) tag_d = TAG_D;
    else if (if_win)       tag_d = TAG_IF;
  end

  always_ff @(posedge clk) begin
    if (rst) tag_q <= TAG_NONE;
    else     tag_q <= tag_d;
  end

  assign bus.if_rvalid = (tag_q == TAG_IF);
  assign bus.d_rvalid  = (tag_q == TAG_D);
  assign bus.if_rdata  = bus.if_rvalid ? bus.ram_rdata : '0;
  assign bus.d_rdata   = bus.d_rvalid  ? bus.ram_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a cycle-level priority/memory model.
// Honours `define ARB_STARVE_GUARD_EN to match the DUT build.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LIMIT = 3;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif
  localparam int EXP_FIRST = STARVE_EN ? 4 : 0;

  logic clk = 1'b0;
  logic rst;
  logic hold_o;
  logic ram_init;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .hold_o (hold_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'h0050_0093;
    return 32'hC0DE_0000 + 32'(i) * 32'h0001_0003;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a[9:2]);
  endfunction

  // Behavioural single-port RAM with one-cycle read latency.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else if (bus.ram_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.ram_we[b]) mem[widx(bus.ram_addr)][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
      bus.ram_rdata <= mem[widx(bus.ram_addr)];
    end
  end

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_mem [256];
  int          m_starve = 0;
  bit          e_ifv = 1'b0, e_dv = 1'b0;
  logic [31:0] e_ifd, e_dd;
  bit          g_if, g_d, obs_if_gnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs already driven just after the previous edge.
  task automatic step(input bit rst_late);
    bit dp, frc, eg_if, eg_d, ehold;
    dp    = bus.d_ren || (bus.d_wen != 4'b0);
    frc   = STARVE_EN && bus.if_req && (m_starve >= LIMIT);
    eg_if = 1'b0;
    eg_d  = 1'b0;
    if (!rst) begin
      if (frc)             eg_if = 1'b1;
      else if (dp)         eg_d  = 1'b1;
      else if (bus.if_req) eg_if = 1'b1;
    end
    ehold = !rst && ((bus.if_req && !eg_if) || (dp && !eg_d));
    #4;
    chk("if_gnt", 32'(bus.if_gnt), 32'(eg_if));
    chk("d_gnt", 32'(bus.d_gnt), 32'(eg_d));
    chk("hold_o", 32'(hold_o), 32'(ehold));
    chk("ram_en", 32'(bus.ram_en), 32'(eg_if | eg_d));
    chk("ram_we", 32'(bus.ram_we), eg_d ? 32'(bus.d_wen) : 32'h0);
    if (eg_if || eg_d) chk("ram_addr", bus.ram_addr, eg_d ? bus.d_addr : bus.if_addr);
    if (eg_d && bus.d_wen != 4'b0) chk("ram_wdata", bus.ram_wdata, bus.d_wdata);
    g_if = eg_if;
    g_d = eg_d;
    obs_if_gnt = bus.if_gnt;
    if (rst_late) rst = 1'b1;
    if (rst) begin
      e_ifv = 1'b0;
      e_dv = 1'b0;
      m_starve = 0;
    end else begin
      e_ifv = eg_if;
      e_ifd = m_mem[widx(bus.if_addr)];
      e_dv = eg_d && (bus.d_wen == 4'b0);
      e_dd = m_mem[widx(bus.d_addr)];
      if (eg_d)
        for (int b = 0; b < 4; b++)
          if (bus.d_wen[b]) m_mem[widx(bus.d_addr)][8*b +: 8] = bus.d_wdata[8*b +: 8];
      if (!bus.if_req || eg_if) m_starve = 0;
      else if (m_starve < LIMIT) m_starve++;
    end
    @(posedge clk);
    #1;
    chk("if_rvalid", 32'(bus.if_rvalid), 32'(e_ifv));
    chk("d_rvalid", 32'(bus.d_rvalid), 32'(e_dv));
    if (e_ifv) chk("if_rdata", bus.if_rdata, e_ifd);
    if (e_dv) chk("d_rdata", bus.d_rdata, e_dd);
  endtask

  task automatic idle_inputs();
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_ren   = 1'b0;
    bus.d_wen   = 4'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
  endtask

  initial begin
    bit p_if, p_d;
    int kind, first;

    ram_init = 1'b1;
    rst = 1'b1;
    idle_inputs();
    for (int i = 0; i < 256; i++) m_mem[i] = init_word(i);
    @(posedge clk);
    #1;
    ram_init = 1'b0;

    // Requests during reset must be ignored
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    bus.d_ren = 1'b1;  bus.d_addr = 32'h20;
    step(1'b0);
    step(1'b0);

    rst = 1'b0;
    idle_inputs();
    step(1'b0);
    chk("rst_if_rdata", bus.if_rdata, 32'h0);
    chk("rst_d_rdata", bus.d_rdata, 32'h0);

    // Lone fetch
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    step(1'b0);
    chk("fetch_gnt", 32'(obs_if_gnt), 32'h1);
    chk("fetch_rdata", bus.if_rdata, 32'h0050_0093);
    idle_inputs();

    // Store and fetch to the same word in one cycle
    bus.d_wen = 4'b1111; bus.d_addr = 32'h80; bus.d_wdata = 32'hDEAD_BEEF;
    bus.if_req = 1'b1;   bus.if_addr = 32'h80;
    step(1'b0);
    bus.d_wen = 4'b0; bus.d_addr = '0; bus.d_wdata = '0;
    step(1'b0);
    bus.if_req = 1'b0;
    chk("raw_rvalid", 32'(bus.if_rvalid), 32'h1);
    chk("raw_rdata", bus.if_rdata, 32'hDEAD_BEEF);
    step(1'b0);

    // Load and fetch held together: back-to-back reads
    bus.d_ren = 1'b1; bus.d_addr = 32'h20;
    bus.if_req = 1'b1; bus.if_addr = 32'h24;
    step(1'b0);
    bus.d_ren = 1'b0;
    step(1'b0);
    bus.if_req = 1'b0;
    step(1'b0);

    // Fetch held against continuous data traffic
    first = 0;
    bus.if_req = 1'b1; bus.if_addr = 32'h30;
    for (int k = 1; k <= 6; k++) begin
      bus.d_ren = 1'b1; bus.d_addr = 32'(k * 4);
      step(1'b0);
      if (obs_if_gnt && first == 0) first = k;
    end
    chk("starve_first_fetch", 32'(first), 32'(EXP_FIRST));
    idle_inputs();
    step(1'b0);

    // Load granted, then reset sampled on the closing edge
    bus.d_ren = 1'b1; bus.d_addr = 32'h40;
    step(1'b1);
    chk("rst_kill_d_rvalid", 32'(bus.d_rvalid), 32'h0);
    chk("rst_kill_d_rdata", bus.d_rdata, 32'h0);
    rst = 1'b0;
    idle_inputs();
    step(1'b0);

    // Randomized traffic; requesters hold until granted
    p_if = 1'b0;
    p_d = 1'b0;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      if (!p_if && $urandom_range(0, 1) == 1) begin
        p_if = 1'b1;
        bus.if_addr = 32'($urandom_range(0, 15)) << 2;
      end
      bus.if_req = p_if;
      if (!p_d && $urandom_range(0, 2) != 0) begin
        p_d = 1'b1;
        kind = $urandom_range(0, 2);
        bus.d_ren   = (kind != 1);
        bus.d_wen   = (kind != 0) ? 4'($urandom_range(1, 15)) : 4'b0;
        bus.d_addr  = 32'($urandom_range(0, 15)) << 2;
        bus.d_wdata = $urandom;
      end
      if (!p_d) begin
        bus.d_ren = 1'b0;
        bus.d_wen = 4'b0;
      end
      step(1'b0);
      if (g_if) p_if = 1'b0;
      if (g_d) p_d = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address width of all ports.
REQ-002 Parameter: DATA_W, 32, data width of all ports.
REQ-003 Parameter: STARVE_LIMIT, 3, consecutive denied fetch cycles before fetch is forced.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset: clk input 1, core clock; rst input 1, synchronous active-high reset.
REQ-005 Instruction-fetch port: if_req input 1, fetch request; if_addr input ADDR_W, fetch address; if_gnt output 1, fetch granted this cycle; if_rdata output DATA_W, fetched word; if_rvalid output 1, if_rdata valid.
REQ-006 Data port: d_ren input 1, load request; d_wen input 4, store byte enables; d_addr input ADDR_W, access address; d_wdata input DATA_W, store data; d_gnt output 1, data access granted; d_rdata output DATA_W, load word; d_rvalid output 1, d_rdata valid.
REQ-007 RAM port: ram_en output 1, access enable; ram_we output 4, byte write enables; ram_addr output ADDR_W; ram_wdata output DATA_W; ram_rdata input DATA_W, synchronous read data one cycle after ram_en.
REQ-008 hold_o output 1: pipeline stall to the core control unit.

Function
REQ-009 Exactly one requester SHALL be granted per cycle; if_gnt and d_gnt SHALL be combinational, never both high.
REQ-010 A data request is pending when d_ren=1 or d_wen!=0; if both are set, the store takes priority and d_ren is ignored for that grant.
REQ-011 Default priority: data store > data load > fetch.
REQ-012 The granted requester's address, byte enables and wdata SHALL drive ram_* combinationally in the grant cycle; ram_en=0 and ram_we=0 when nothing is granted.
REQ-013 Requesters SHALL hold req/address/data stable until granted; the arbiter SHALL NOT latch ungranted requests.
REQ-014 A store SHALL complete in its grant cycle; no rvalid is generated for it.
REQ-015 A read granted in cycle N SHALL be recorded in a registered tag (NONE/IF/D); in cycle N+1 the matching rvalid SHALL pulse for one cycle with rdata = ram_rdata.
REQ-016 Back-to-back reads SHALL be sustained at one per cycle (tag updated every cycle).
REQ-017 hold_o = (if_req & ~if_gnt) | (data pending & ~d_gnt).
REQ-018 Same-address store and fetch in the same cycle: store granted; fetch granted next cycle and SHALL return the newly written word.
REQ-019 Idle cycle (no requests): tag SHALL become NONE, hold_o=0.

Reset
REQ-020 On rst=1 at a clk edge: tag=NONE, starvation counter=0, if_rvalid=0, d_rvalid=0, if_rdata=0, d_rdata=0.
REQ-021 A read granted in the cycle in which rst is sampled SHALL NOT produce rvalid after reset.
REQ-022 While rst=1, if_gnt, d_gnt, ram_en, ram_we and hold_o SHALL be 0.

Configuration
REQ-023 Macro ARB_STARVE_GUARD_EN compiled in: a counter SHALL increment each cycle with if_req=1 and if_gnt=0, clear on any fetch grant or if_req=0, and saturate at STARVE_LIMIT.
REQ-024 With ARB_STARVE_GUARD_EN, when the counter equals STARVE_LIMIT, fetch SHALL win the next grant over any data request, then the counter SHALL clear.
REQ-025 Without ARB_STARVE_GUARD_EN: no counter is present, and strict fixed priority per REQ-011 applies.

Verification
REQ-026 if_req=1 alone, if_addr=0x10, RAM[0x10]=0x00500093 -> if_gnt=1 cycle N; if_rvalid=1 with if_rdata=0x00500093 at N+1; hold_o=0.
REQ-027 d_wen=4'b1111, d_addr=0x80, d_wdata=0xDEADBEEF, and if_req at 0x80 in the same cycle -> d_gnt=1, hold_o=1; next cycle if_gnt=1; following cycle if_rdata=0xDEADBEEF.
REQ-028 d_ren and if_req both held 1 -> d_gnt cycle N, d_rvalid N+1, if_gnt N+1, if_rvalid N+2; one-per-cycle throughput.
REQ-029 ARB_STARVE_GUARD_EN, STARVE_LIMIT=3, data requests every cycle with if_req held -> if_gnt on the 4th cycle; without the macro, if_gnt never asserts until data requests stop.
REQ-030 d_ren granted at cycle N with rst=1 at edge N+1 -> d_rvalid stays 0, all outputs at reset values.
